// File: rtl/seven_seg_serial_sender.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_serial_sender
// Purpose  : Shadows four 7-seg digit patterns and streams each changed digit
//            as an 11-edge clock/data frame to the display controller.
// Revision : 1.0  initial release
// ============================================================================
module seven_seg_serial_sender #(
   parameter int CLK_DIV        = 12,
   parameter int GAP_CYCLES     = 48,
   parameter int REFRESH_PERIOD = 2_400_000
) (
   input  logic       clock,
   input  logic       resetN,
   input  logic       wrValid,
   output logic       wrReady,
   input  logic [1:0] wrDigit,
   input  logic [7:0] wrSegments,
   input  logic       refreshNow,
   output logic       busy,
   output logic       frameDone,
   output logic       serialClockOut,
   output logic       serialDataOut
);

   localparam int DIV_W = (CLK_DIV > 1)        ? $clog2(CLK_DIV)        : 1;
   localparam int GAP_W = (GAP_CYCLES > 1)     ? $clog2(GAP_CYCLES)     : 1;
   localparam int TMR_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

   localparam logic [DIV_W-1:0] c_divLast   = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] c_gapLast   = GAP_W'(GAP_CYCLES - 1);
   localparam logic [TMR_W-1:0] c_tmrLast   = TMR_W'(REFRESH_PERIOD - 1);
   localparam bit               c_refreshEn = (REFRESH_PERIOD != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_BIT_LO = 3'd2,
      S_BIT_HI = 3'd3,
      S_GAP    = 3'd4
   } state_t;

   state_t           r_state;
   logic [7:0]       r_shadow [4];
   logic [3:0]       r_dirty;
   logic [1:0]       r_rrPtr;
   logic [TMR_W-1:0] r_timer;
   logic [9:0]       r_shiftReg;
   logic [3:0]       r_bitCnt;
   logic [DIV_W-1:0] r_divCnt;
   logic [GAP_W-1:0] r_gapCnt;
   logic             r_running;
   logic             r_frameDone;
   logic             r_sclk;
   logic             r_sdat;

   logic [1:0]       w_pick;
   logic             w_refresh;

   // Scan from the highest offset down so the nearest dirty digit to rrPtr wins.
   always_comb begin
      w_pick = r_rrPtr;
      for (int i = 3; i >= 0; i--) begin
         if (r_dirty[r_rrPtr + 2'(i)]) begin
            w_pick = r_rrPtr + 2'(i);
         end
      end
   end

   assign w_refresh = refreshNow | (c_refreshEn && (r_timer == c_tmrLast));

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state     <= S_IDLE;
         for (int i = 0; i < 4; i++) begin
            r_shadow[i] <= 8'h00;
         end
         r_dirty     <= 4'b1111;
         r_rrPtr     <= 2'd0;
         r_timer     <= '0;
         r_shiftReg  <= 10'd0;
         r_bitCnt    <= 4'd0;
         r_divCnt    <= '0;
         r_gapCnt    <= '0;
         r_running   <= 1'b0;
         r_frameDone <= 1'b0;
         r_sclk      <= 1'b0;
         r_sdat      <= 1'b0;
      end else begin
         r_running   <= 1'b1;
         r_frameDone <= 1'b0;

         if (w_refresh) begin
            r_timer <= '0;
         end else if (c_refreshEn) begin
            r_timer <= r_timer + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               r_sclk <= 1'b0;
               r_sdat <= 1'b0;
               if (|r_dirty) begin
                  r_state <= S_LOAD;
               end
            end

            S_LOAD: begin
               r_shiftReg       <= {w_pick, r_shadow[w_pick]};
               r_dirty[w_pick]  <= 1'b0;
               r_rrPtr          <= w_pick + 2'd1;
               r_bitCnt         <= 4'd0;
               r_divCnt         <= '0;
               r_sdat           <= w_pick[1];
               r_state          <= S_BIT_LO;
            end

            S_BIT_LO: begin
               r_sdat <= (r_bitCnt == 4'd10) ? 1'b0 : r_shiftReg[9];
               if (r_divCnt == c_divLast) begin
                  r_divCnt <= '0;
                  r_sclk   <= 1'b1;
                  r_state  <= S_BIT_HI;
                  if (CLK_DIV == 1 && r_bitCnt == 4'd10) begin
                     r_frameDone <= 1'b1;
                  end
               end else begin
                  r_divCnt <= r_divCnt + 1'b1;
               end
            end

            S_BIT_HI: begin
               if (r_divCnt == c_divLast) begin
                  r_divCnt   <= '0;
                  r_shiftReg <= {r_shiftReg[8:0], 1'b0};
                  r_bitCnt   <= r_bitCnt + 4'd1;
                  r_sclk     <= 1'b0;
                  if (r_bitCnt == 4'd10) begin
                     r_sdat   <= 1'b0;
                     r_gapCnt <= '0;
                     r_state  <= S_GAP;
                  end else begin
                     // Bit 9 drives a zero latch slot; otherwise present the next frame bit.
                     r_sdat  <= (r_bitCnt == 4'd9) ? 1'b0 : r_shiftReg[8];
                     r_state <= S_BIT_LO;
                  end
               end else begin
                  r_divCnt <= r_divCnt + 1'b1;
                  if (r_bitCnt == 4'd10 && int'(r_divCnt) == CLK_DIV - 2) begin
                     r_frameDone <= 1'b1;
                  end
               end
            end

            S_GAP: begin
               if (r_gapCnt == c_gapLast) begin
                  r_state <= S_IDLE;
               end else begin
                  r_gapCnt <= r_gapCnt + 1'b1;
               end
            end

            default: r_state <= S_IDLE;
         endcase

         // Later assignments take priority: a write beats the LOAD clear, refresh beats both.
         if (wrValid && r_running) begin
            r_shadow[wrDigit] <= wrSegments;
            r_dirty[wrDigit]  <= 1'b1;
         end
         if (w_refresh) begin
            r_dirty <= 4'b1111;
         end
      end
   end

   assign wrReady        = r_running;
   assign busy           = r_running & ((r_state != S_IDLE) | (|r_dirty));
   assign frameDone      = r_frameDone;
   assign serialClockOut = r_sclk;
   assign serialDataOut  = r_sdat;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_serial_sender.sv
`default_nettype none
// Testbench for seven_seg_serial_sender: directed scenarios plus random writes/refreshes,
// scored against a frame-level model of the dirty-digit scheduler and a serial-line decoder.
module tb_seven_seg_serial_sender;

   localparam int CLK_DIV        = 2;
   localparam int GAP_CYCLES     = 4;
   localparam int REFRESH_PERIOD = 1000;
   localparam int FRAME_LEN      = 22 * CLK_DIV + 1;

   logic       clock      = 1'b0;
   logic       resetN     = 1'b0;
   logic       wrValid    = 1'b0;
   logic       wrReady;
   logic [1:0] wrDigit    = 2'd0;
   logic [7:0] wrSegments = 8'h00;
   logic       refreshNow = 1'b0;
   logic       busy;
   logic       frameDone;
   logic       serialClockOut;
   logic       serialDataOut;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   int         cyc, loadAt, idleAt, rr, timer;
   logic [3:0] dirty;
   logic [7:0] shadow [4];
   bit         running;
   logic [9:0] expQ [$];

   // line decoder state
   int         monCyc, nBits, lastRise, fdInFrame, fdTotal;
   logic [9:0] frameBits;
   logic       prevSclk, prevFd;
   logic [9:0] frameLog [$];

   seven_seg_serial_sender #(
      .CLK_DIV        (CLK_DIV),
      .GAP_CYCLES     (GAP_CYCLES),
      .REFRESH_PERIOD (REFRESH_PERIOD)
   ) dut (
      .clock          (clock),
      .resetN         (resetN),
      .wrValid        (wrValid),
      .wrReady        (wrReady),
      .wrDigit        (wrDigit),
      .wrSegments     (wrSegments),
      .refreshNow     (refreshNow),
      .busy           (busy),
      .frameDone      (frameDone),
      .serialClockOut (serialClockOut),
      .serialDataOut  (serialDataOut)
   );

   initial forever #5 clock = ~clock;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      cyc     = 0;
      loadAt  = -100;
      idleAt  = 0;
      rr      = 0;
      timer   = 0;
      dirty   = 4'b1111;
      running = 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] = 8'h00;
      expQ.delete();
   endtask

   task automatic monReset();
      nBits     = 0;
      lastRise  = 0;
      fdInFrame = 0;
      frameBits = 10'd0;
      prevSclk  = 1'b0;
      prevFd    = 1'b0;
   endtask

   // Advance the model across one rising edge, using the values of the cycle just ended.
   task automatic modelEdge();
      int p, d;
      logic [3:0] nd;
      if (!resetN) begin
         modelReset();
         return;
      end
      p  = cyc;
      nd = dirty;
      cyc++;
      if (loadAt == p) begin
         d = -1;
         for (int k = 0; k < 4; k++) begin
            if (d < 0 && dirty[(rr + k) % 4]) d = (rr + k) % 4;
         end
         expQ.push_back({2'(d), shadow[d]});
         nd[d]  = 1'b0;
         rr     = (d + 1) % 4;
         idleAt = p + FRAME_LEN + GAP_CYCLES;
      end else if (p >= idleAt && dirty != 4'd0) begin
         loadAt = cyc;
      end
      if (wrValid && running) begin
         shadow[wrDigit] = wrSegments;
         nd[wrDigit]     = 1'b1;
      end
      if (refreshNow || timer == REFRESH_PERIOD - 1) begin
         nd    = 4'b1111;
         timer = 0;
      end else begin
         timer++;
      end
      dirty   = nd;
      running = 1'b1;
   endtask

   task automatic monitor();
      bit idle;
      logic [9:0] exp;
      monCyc++;
      if (!resetN) begin
         checkEq("resetOutputs", 32'({busy, frameDone, serialClockOut, serialDataOut, wrReady}), 32'd0);
         monReset();
         return;
      end
      idle = (cyc >= idleAt) && (loadAt != cyc);
      checkEq("busy", 32'(busy), 32'(running && !(idle && dirty == 4'd0)));
      checkEq("wrReady", 32'(wrReady), 32'(running));
      if (idle) checkEq("idleLines", 32'({serialClockOut, serialDataOut}), 32'd0);
      if (prevFd) checkEq("frameDoneLastHigh", 32'(serialClockOut), 32'd0);
      if (serialClockOut && !prevSclk) begin
         nBits++;
         if (nBits > 1) checkEq("sclkPeriod", 32'(monCyc - lastRise), 32'(2 * CLK_DIV));
         lastRise = monCyc;
         if (nBits <= 10) begin
            frameBits = {frameBits[8:0], serialDataOut};
         end else begin
            checkEq("latchBit", 32'(serialDataOut), 32'd0);
            checkEq("frameQueued", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
               exp = expQ.pop_front();
               checkEq("frame", 32'(frameBits), 32'(exp));
            end
            frameLog.push_back(frameBits);
         end
      end
      if (frameDone) begin
         fdTotal++;
         fdInFrame++;
         checkEq("frameDonePhase", 32'({serialClockOut, nBits == 11}), 32'd3);
      end
      if (!serialClockOut && prevSclk && nBits == 11) begin
         checkEq("frameDoneCount", 32'(fdInFrame), 32'd1);
         nBits     = 0;
         fdInFrame = 0;
      end
      prevSclk = serialClockOut;
      prevFd   = frameDone;
   endtask

   task automatic step();
      @(posedge clock);
      modelEdge();
      @(negedge clock);
      monitor();
   endtask

   task automatic waitIdle(input int limit);
      int n = 0;
      while (busy && n < limit) begin
         step();
         n++;
      end
      checkEq("idleTimeout", 32'(busy), 32'd0);
   endtask

   task automatic writeDigit(input logic [1:0] d, input logic [7:0] seg);
      wrValid    = 1'b1;
      wrDigit    = d;
      wrSegments = seg;
      step();
      wrValid    = 1'b0;
   endtask

   task automatic checkBlankSequence(input int base, input string tag);
      logic [9:0] e;
      checkEq({tag, "Count"}, 32'(frameLog.size() - base), 32'd4);
      for (int i = 0; i < 4 && base + i < frameLog.size(); i++) begin
         e = {2'(i), 8'h00};
         checkEq(tag, 32'(frameLog[base + i]), 32'(e));
      end
   endtask

   initial begin
      int base, n, fd0;
      modelReset();
      monReset();
      monCyc  = 0;
      fdTotal = 0;

      // power-up blanking sequence
      repeat (3) step();
      resetN = 1'b1;
      step();
      waitIdle(2000);
      checkBlankSequence(0, "blankFrame");

      // single write: frame content, busy window, one frameDone
      base = frameLog.size();
      fd0  = fdTotal;
      writeDigit(2'd2, 8'h5B);
      n = 0;
      while (busy && n < 500) begin
         n++;
         step();
      end
      checkEq("busyLength", 32'(n), 32'(FRAME_LEN + GAP_CYCLES + 1));
      checkEq("singleFrameCount", 32'(frameLog.size() - base), 32'd1);
      if (frameLog.size() > base) checkEq("singleFrame", 32'(frameLog[base]), 32'h25B);
      checkEq("singleFrameDone", 32'(fdTotal - fd0), 32'd1);

      // back-to-back writes while idle
      base = frameLog.size();
      wrValid = 1'b1; wrDigit = 2'd3; wrSegments = 8'h4F; step();
      wrDigit = 2'd1; wrSegments = 8'h06; step();
      wrDigit = 2'd0; wrSegments = 8'h66; step();
      wrValid = 1'b0;
      waitIdle(2000);
      checkEq("burstCount", 32'(frameLog.size() - base), 32'd3);

      // rewrite of a digit mid-shift goes out in a following frame
      base = frameLog.size();
      writeDigit(2'd1, 8'h21);
      n = 0;
      while (!serialClockOut && n < 100) begin
         step();
         n++;
      end
      checkEq("midShiftStart", 32'(serialClockOut), 32'd1);
      writeDigit(2'd1, 8'h3F);
      waitIdle(2000);
      checkEq("midShiftCount", 32'(frameLog.size() - base), 32'd2);
      if (frameLog.size() >= base + 2) begin
         checkEq("midShiftFirst", 32'(frameLog[base]), 32'h121);
         checkEq("midShiftSecond", 32'(frameLog[base + 1]), 32'h13F);
      end

      // refreshNow while busy resends everything after the current frame
      base = frameLog.size();
      writeDigit(2'd0, 8'h7F);
      repeat (10) step();
      refreshNow = 1'b1;
      step();
      refreshNow = 1'b0;
      waitIdle(2000);
      checkEq("refreshResend", 32'(frameLog.size() - base >= 5), 32'd1);

      // periodic refresh with no host activity
      repeat (2500) step();
      waitIdle(2000);

      // random traffic
      for (int i = 0; i < 6000; i++) begin
         wrValid    = ($urandom_range(0, 7) == 0);
         wrDigit    = 2'($urandom_range(0, 3));
         wrSegments = 8'($urandom);
         refreshNow = ($urandom_range(0, 299) == 0);
         step();
      end
      wrValid    = 1'b0;
      refreshNow = 1'b0;
      waitIdle(3000);
      checkEq("queueDrained", 32'(expQ.size()), 32'd0);

      // asynchronous reset during a high serial-clock phase
      n = 0;
      while (!serialClockOut && n < 2000) begin
         step();
         n++;
      end
      checkEq("highPhaseFound", 32'(serialClockOut), 32'd1);
      #2 resetN = 1'b0;
      #1;
      checkEq("asyncSclk", 32'(serialClockOut), 32'd0);
      checkEq("asyncSdat", 32'(serialDataOut), 32'd0);
      checkEq("asyncBusy", 32'(busy), 32'd0);
      checkEq("asyncReady", 32'(wrReady), 32'd0);
      modelReset();
      monReset();
      repeat (2) step();
      resetN = 1'b1;
      base = frameLog.size();
      step();
      waitIdle(2000);
      checkBlankSequence(base, "reblankFrame");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
